data_mem_bus: RTL
=================

# data_mem_bus

Data-side responder for the pipelined MIPS core: serves the core's memory-stage port (write strobe, address, write data, read data) with a word-addressed RAM and a small memory-mapped I/O window (LEDs, switches, cycle counter, down-counting timer). Sits beside the core at the SoC top, on the other end of the core's memory-stage port. Reads are combinational in the memory stage. Writes commit at the clock edge ending that stage. The core never stalls.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_FF00: base of the 256-byte I/O window.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `memwrite` in 1: write strobe from the memory stage.
- `addr` in 32: byte address from the memory stage; `addr[1:0]` ignored (word access only).
- `writedata` in 32: store data.
- `readdata` out 32: load data, combinational from `addr` and current state.
- `sw` in 16: external switches, asynchronous.
- `led` out 16: LED register.
- `irq` out 1: timer interrupt, registered.

## Operation
- Decode:
  - RAM when `addr < DEPTH_WORDS*4`, word index `addr[log2(DEPTH_WORDS)+1:2]`.
  - MMIO when `addr[31:8] == MMIO_BASE[31:8]`.
  - Any other address is unmapped: reads return 0, writes are dropped.
- MMIO offsets (`addr[7:0]`):
  - 0x00 LED, RW, low 16 bits; upper read bits are 0.
  - 0x04 SW, RO: the 2-flop-synchronized `sw`, zero-extended.
  - 0x08 CYCLE, RO: free-running 32-bit count, wraps 0xFFFF_FFFF→0. Any write clears it to 0.
  - 0x0C TLOAD, RW: a write also loads TCOUNT.
  - 0x10 TCTRL:
    - bit0 EN.
    - bit1 AUTO (auto-reload).
    - bit2 EXP: expired flag; writing 1 clears it, writing 0 has no effect on it.
    - bit3 IRQEN.
    - Other bits read 0.
  - 0x14 TCOUNT, RO.
  - Other offsets in the window read 0 and ignore writes.
- Timer, per cycle:
  - Decrements when EN=1 and TCOUNT≠0.
  - On a 1→0 step: EXP←1; TCOUNT←TLOAD if AUTO=1, else 0.
  - Holds at 0 when AUTO=0.
- `irq` = registered (EXP & IRQEN).
- Collision rules:
  - TLOAD write in the same cycle as expiry: the written value goes to TCOUNT, and EXP still sets.
  - W1C of EXP in the same cycle as a new expiry: EXP stays 1 (set wins).
  - Write to CYCLE on the wrap cycle: the result is 0.
- Reset (`rst`=0 at an edge) sets LED, CYCLE, TLOAD, TCTRL, TCOUNT, `irq` and the sw synchronizer to 0, so `led`=0 and `irq`=0.
  - RAM contents are not reset.
  - A reset asserted mid-countdown aborts the countdown; no EXP is produced.

## Timing
- Read latency 0: `readdata` reflects state as of the last edge.
  - A load from an address written in the previous cycle returns the new data.
  - A load in the same cycle as a store to that address returns the old data.
- Write latency 1: committed at the edge where `memwrite`=1.
- CYCLE reads N+k when read k cycles after a read returning N.
- `sw` change is visible at SW after 2 edges.
- `irq` rises 1 cycle after EXP sets.
- TCOUNT=1 with EN set gives EXP=1 at the next edge.

## Configuration
- `DMEM_TIMER_EN`
  - Defined: the timer (TLOAD/TCTRL/TCOUNT and `irq`) is present as above.
  - Undefined: offsets 0x0C–0x14 read 0 and ignore writes, `irq` is tied 0, and no timer flops are built.

## Structure
- Shared package `dmem_pkg`:
  - Register offsets (OFF_LED, OFF_SW, OFF_CYCLE, OFF_TLOAD, OFF_TCTRL, OFF_TCOUNT).
  - TCTRL bit positions.
  - Region-decode enum {RGN_RAM, RGN_MMIO, RGN_NONE}.
- One sub-module, `dmem_timer`: TLOAD/TCTRL/TCOUNT and the `irq` register.
  - Inputs: write strobes and data.
  - Outputs: register values and `irq`.
- RAM array, decode, LED, CYCLE and the sw synchronizer stay in the top.

## Test plan
- RAM: sw 0xDEADBEEF to 0x0000_0010, then lw 0x10 next cycle → 0xDEADBEEF. lw 0x0000_1000 (DEPTH 1024) → 0. A write there must not alias onto word 0.
- Reset: hold `rst`=0 for 2 cycles mid-run → `led`=0, CYCLE read right after release = 0, `irq`=0.
- Cycle counter:
  - Write 0 to CYCLE, then read 5 cycles later → 5.
  - Force 0xFFFF_FFFF, read next cycle → 0.
- Timer one-shot:
  - Write TLOAD=3, TCTRL=0x9 → EXP=1 after 3 edges, `irq`=1 one cycle later, TCOUNT holds 0.
  - Write TCTRL=0xD (W1C) → `irq` falls next cycle.
- Timer auto-reload:
  - TLOAD=2, TCTRL=0x3 → TCOUNT sequence 2,1,2,1.
  - W1C issued on an expiry edge → EXP remains 1.
- Switches/LED:
  - `sw`=0xA5A5 → SW reads 0x0000_A5A5 from the 2nd edge on.
  - Write LED 0x1234_5678 → `led`=0x5678 and LED reads 0x0000_5678.
  - Unmapped 0x8000_0000 reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory bus: MMIO register offsets,
// timer control bit positions and the address-region decode.
package dmem_pkg;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_TLOAD  = 8'h0C;
    localparam logic [7:0] OFF_TCTRL  = 8'h10;
    localparam logic [7:0] OFF_TCOUNT = 8'h14;

    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_AUTO  = 1;
    localparam int TCTRL_EXP   = 2;
    localparam int TCTRL_IRQEN = 3;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_MMIO,
        RGN_NONE
    } region_e;

    // RAM takes priority; the MMIO window is a single 256-byte page.
    function automatic region_e decodeRegion(
        input logic [31:0] addr,
        input logic [31:0] ramBytes,
        input logic [23:0] mmioPage
    );
        region_e rgn;
        if (addr < ramBytes) begin
            rgn = RGN_RAM;
        end else if (addr[31:8] == mmioPage) begin
            rgn = RGN_MMIO;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Down-counting timer with auto-reload, sticky expiry flag and registered irq.
// Only built when DMEM_TIMER_EN is defined.
`ifdef DMEM_TIMER_EN
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tloadWe_i,
    input  logic        tctrlWe_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tload_o,
    output logic [3:0]  tctrl_o,
    output logic [31:0] tcount_o,
    output logic        irq_o
);

    logic [31:0] tload_q, tload_d;
    logic [31:0] tcount_q, tcount_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        exp_q, exp_d;
    logic        irqEn_q, irqEn_d;
    logic        irq_q, irq_d;
    logic        expire;

    // A TLOAD write beats both reload and decrement; a new expiry beats W1C.
    always_comb begin
        tload_d  = tload_q;
        tcount_d = tcount_q;
        en_d     = en_q;
        auto_d   = auto_q;
        irqEn_d  = irqEn_q;
        expire   = en_q && (tcount_q == 32'd1);

        if (tloadWe_i) begin
            tload_d = wdata_i;
        end
        if (tctrlWe_i) begin
            en_d    = wdata_i[TCTRL_EN];
            auto_d  = wdata_i[TCTRL_AUTO];
            irqEn_d = wdata_i[TCTRL_IRQEN];
        end

        if (tloadWe_i) begin
            tcount_d = wdata_i;
        end else if (expire) begin
            tcount_d = auto_q ? tload_q : 32'd0;
        end else if (en_q && (tcount_q != 32'd0)) begin
            tcount_d = tcount_q - 32'd1;
        end

        exp_d = expire | (exp_q & ~(tctrlWe_i & wdata_i[TCTRL_EXP]));
        irq_d = exp_q & irqEn_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tload_q  <= '0;
            tcount_q <= '0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            exp_q    <= 1'b0;
            irqEn_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            exp_q    <= exp_d;
            irqEn_q  <= irqEn_d;
            irq_q    <= irq_d;
        end
    end

    assign tload_o              = tload_q;
    assign tcount_o             = tcount_q;
    assign tctrl_o[TCTRL_EN]    = en_q;
    assign tctrl_o[TCTRL_AUTO]  = auto_q;
    assign tctrl_o[TCTRL_EXP]   = exp_q;
    assign tctrl_o[TCTRL_IRQEN] = irqEn_q;
    assign irq_o                = irq_q;

endmodule
`endif

// File: rtl/data_mem_bus.sv
// Data-side responder for the MIPS memory stage: word RAM plus an MMIO page
// (LED, switches, cycle counter, timer). The timer exists only with DMEM_TIMER_EN.
module data_mem_bus
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_q [DEPTH_WORDS];
    region_e       rgn;
    logic [AW-1:0] ramIdx;
    logic [7:0]    mmioOff;
    logic          ramWe;
    logic          mmioWe;
    logic [15:0]   led_q, led_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [15:0]   swSync1_q, swSync2_q;
    logic [31:0]   tloadVal;
    logic [3:0]    tctrlVal;
    logic [31:0]   tcountVal;
    logic          irqVal;
    logic [31:0]   mmioRd;
    logic [1:0]    unusedByteLane;

    assign unusedByteLane = addr[1:0];
    assign rgn     = decodeRegion(addr, RAM_BYTES, MMIO_BASE[31:8]);
    assign ramIdx  = addr[AW+1:2];
    assign mmioOff = {addr[7:2], 2'b00};
    assign ramWe   = memwrite && (rgn == RGN_RAM);
    assign mmioWe  = memwrite && (rgn == RGN_MMIO);

    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem_q[ramIdx] <= writedata;
        end
    end

    // Any write to CYCLE clears it, which also covers the wrap cycle.
    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (mmioWe && (mmioOff == OFF_LED)) begin
            led_d = writedata[15:0];
        end
        if (mmioWe && (mmioOff == OFF_CYCLE)) begin
            cycle_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q     <= '0;
            cycle_q   <= '0;
            swSync1_q <= '0;
            swSync2_q <= '0;
        end else begin
            led_q     <= led_d;
            cycle_q   <= cycle_d;
            swSync1_q <= sw;
            swSync2_q <= swSync1_q;
        end
    end

`ifdef DMEM_TIMER_EN
    dmem_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .tloadWe_i (mmioWe && (mmioOff == OFF_TLOAD)),
        .tctrlWe_i (mmioWe && (mmioOff == OFF_TCTRL)),
        .wdata_i   (writedata),
        .tload_o   (tloadVal),
        .tctrl_o   (tctrlVal),
        .tcount_o  (tcountVal),
        .irq_o     (irqVal)
    );
`else
    assign tloadVal  = '0;
    assign tctrlVal  = '0;
    assign tcountVal = '0;
    assign irqVal    = 1'b0;
`endif

    always_comb begin
        mmioRd = '0;
        case (mmioOff)
            OFF_LED:    mmioRd = {16'h0000, led_q};
            OFF_SW:     mmioRd = {16'h0000, swSync2_q};
            OFF_CYCLE:  mmioRd = cycle_q;
            OFF_TLOAD:  mmioRd = tloadVal;
            OFF_TCTRL:  mmioRd = {28'h0, tctrlVal};
            OFF_TCOUNT: mmioRd = tcountVal;
            default:    mmioRd = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        case (rgn)
            RGN_RAM:  readdata = mem_q[ramIdx];
            RGN_MMIO: readdata = mmioRd;
            default:  readdata = '0;
        endcase
    end

    assign led = led_q;
    assign irq = irqVal;

endmodule
